// File: rtl/reg_scoreboard.sv
// Issue-side RAW/WAW hazard scoreboard: per-register in-flight write counters,
// decode/execute handshake gating, writeback countdown and hazard-stall perf counter.
module reg_scoreboard #(
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              prev_stalled,
    input  logic              next_stalled,
    output logic              stall_prev,
    output logic              stall_next,
    input  logic [4:0]        issue_rs1,
    input  logic [4:0]        issue_rs2,
    input  logic              issue_uses_rs1,
    input  logic              issue_uses_rs2,
    input  logic [4:0]        issue_rd,
    input  logic              issue_is_reg_write,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    output logic [31:0]       busy_mask,
    output logic [PERF_W-1:0] hazard_stall_cycles,
    output logic              underflow_err
);

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1'b1);

    logic [CNT_W-1:0]  cnt_r [0:31];
    logic [CNT_W-1:0]  cnt_next_s [0:31];
    logic [31:0]       busy_r;
    logic [31:0]       busy_next_s;
    logic [31:0]       inc_s;
    logic [31:0]       dec_s;
    logic [PERF_W-1:0] perf_r;
    logic              underflow_r;
    logic              raw_s;
    logic              full_s;
    logic              hazard_s;
    logic              fire_s;
    logic              wb_underflow_s;

    // Hazard detection on current counters and handshake outputs; no writeback bypass.
    always_comb begin
        raw_s          = (issue_uses_rs1 && (cnt_r[issue_rs1] != CNT_ZERO)) ||
                         (issue_uses_rs2 && (cnt_r[issue_rs2] != CNT_ZERO));
        full_s         = issue_is_reg_write && (issue_rd != 5'd0) &&
                         (cnt_r[issue_rd] == CNT_MAX);
        hazard_s       = !prev_stalled && (raw_s || full_s);
        fire_s         = !rst && !flush && !prev_stalled && !next_stalled && !hazard_s;
        stall_prev     = rst || next_stalled || hazard_s;
        stall_next     = rst || prev_stalled || hazard_s;
        wb_underflow_s = wb_valid && (wb_rd != 5'd0) && (cnt_r[wb_rd] == CNT_ZERO) && !flush;
    end

    // Next counter values; x0 stays zero and flush wipes everything.
    always_comb begin
        inc_s       = 32'h0;
        dec_s       = 32'h0;
        busy_next_s = 32'h0;
        for (int r = 0; r < 32; r++) begin
            inc_s[r] = fire_s && issue_is_reg_write && (issue_rd == 5'(r)) && (r != 0);
            dec_s[r] = wb_valid && (wb_rd == 5'(r)) && (r != 0) && (cnt_r[r] != CNT_ZERO);
            if (flush || (r == 0)) begin
                cnt_next_s[r] = CNT_ZERO;
            end else if (inc_s[r] && !dec_s[r]) begin
                cnt_next_s[r] = cnt_r[r] + CNT_ONE;
            end else if (dec_s[r] && !inc_s[r]) begin
                cnt_next_s[r] = cnt_r[r] - CNT_ONE;
            end else begin
                cnt_next_s[r] = cnt_r[r];
            end
            busy_next_s[r] = (cnt_next_s[r] != CNT_ZERO);
        end
    end

    // State registers: counters, busy view, perf counter and sticky underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
            busy_r      <= 32'h0;
            perf_r      <= {PERF_W{1'b0}};
            underflow_r <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_r[r] <= cnt_next_s[r];
            end
            busy_r <= busy_next_s;
            if (hazard_s && !flush && (perf_r != PERF_MAX)) begin
                perf_r <= perf_r + PERF_ONE;
            end
            if (wb_underflow_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign busy_mask           = busy_r;
    assign hazard_stall_cycles = perf_r;
    assign underflow_err       = underflow_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: one task per scenario,
// inline comparisons against hand-computed expectations.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        prev_stalled;
    logic        next_stalled;
    logic        stall_prev;
    logic        stall_next;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_uses_rs1;
    logic        issue_uses_rs2;
    logic [4:0]  issue_rd;
    logic        issue_is_reg_write;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] busy_mask;
    logic [31:0] hazard_stall_cycles;
    logic        underflow_err;

    int tests_run;
    int tests_failed;
    int exp_perf;

    reg_scoreboard #(.CNT_W(2), .PERF_W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .prev_stalled        (prev_stalled),
        .next_stalled        (next_stalled),
        .stall_prev          (stall_prev),
        .stall_next          (stall_next),
        .issue_rs1           (issue_rs1),
        .issue_rs2           (issue_rs2),
        .issue_uses_rs1      (issue_uses_rs1),
        .issue_uses_rs2      (issue_uses_rs2),
        .issue_rd            (issue_rd),
        .issue_is_reg_write  (issue_is_reg_write),
        .wb_valid            (wb_valid),
        .wb_rd               (wb_rd),
        .busy_mask           (busy_mask),
        .hazard_stall_cycles (hazard_stall_cycles),
        .underflow_err       (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; prev_stalled = 1'b1; next_stalled = 1'b0;
        issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_uses_rs1 = 1'b0; issue_uses_rs2 = 1'b0;
        issue_rd = 5'd0; issue_is_reg_write = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
        #1;
    endtask

    task automatic present(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] rd, input logic w);
        prev_stalled = 1'b0;
        issue_rs1 = rs1; issue_uses_rs1 = u1; issue_rs2 = rs2; issue_uses_rs2 = u2;
        issue_rd = rd; issue_is_reg_write = w;
        #1;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1; wb_rd = rd;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        prev_stalled = 1'b0;
        #1;
        tests_run++;
        if (stall_prev !== 1'b1 || stall_next !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_stalls got prev=%0b next=%0b exp 1/1", stall_prev, stall_next);
        end
        tick(); tick();
        idle();
        rst = 1'b0;
        #1;
        tests_run++;
        if (busy_mask !== 32'h0 || hazard_stall_cycles !== 32'd0 || underflow_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state got busy=%h perf=%0d uf=%0b exp 0/0/0",
                     busy_mask, hazard_stall_cycles, underflow_err);
        end
        tests_run++;
        if (stall_prev !== 1'b0 || stall_next !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_stalls got prev=%0b next=%0b exp 0/1", stall_prev, stall_next);
        end
        exp_perf = 0;
    endtask

    task automatic test_raw();
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        tests_run++;
        if (stall_prev !== 1'b0 || stall_next !== 1'b0) begin
            tests_failed++;
            $display("FAIL raw_first_fire got prev=%0b next=%0b exp 0/0", stall_prev, stall_next);
        end
        tick();
        present(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        tests_run++;
        if (busy_mask !== 32'h20) begin
            tests_failed++;
            $display("FAIL raw_busy got %h exp %h", busy_mask, 32'h20);
        end
        tests_run++;
        if (stall_prev !== 1'b1 || stall_next !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_stall got prev=%0b next=%0b exp 1/1", stall_prev, stall_next);
        end
        tick(); tick();
        wb(5'd5);
        tests_run++;
        if (stall_prev !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_no_bypass got %0b exp 1", stall_prev);
        end
        tick();
        exp_perf += 3;
        wb_valid = 1'b0;
        #1;
        tests_run++;
        if (busy_mask !== 32'h0 || stall_prev !== 1'b0 || stall_next !== 1'b0) begin
            tests_failed++;
            $display("FAIL raw_release got busy=%h prev=%0b next=%0b exp 0/0/0",
                     busy_mask, stall_prev, stall_next);
        end
        tests_run++;
        if (hazard_stall_cycles !== 32'(exp_perf)) begin
            tests_failed++;
            $display("FAIL raw_perf got %0d exp %0d", hazard_stall_cycles, exp_perf);
        end
        tick();
        idle();
        tests_run++;
        if (busy_mask !== 32'h40) begin
            tests_failed++;
            $display("FAIL raw_dep_issued got %h exp %h", busy_mask, 32'h40);
        end
        wb(5'd6);
        tick();
        idle();
    endtask

    task automatic test_full();
        for (int i = 0; i < 3; i++) begin
            present(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
            tests_run++;
            if (stall_prev !== 1'b0) begin
                tests_failed++;
                $display("FAIL full_fill%0d got %0b exp 0", i, stall_prev);
            end
            tick();
        end
        tests_run++;
        if (stall_prev !== 1'b1 || busy_mask !== 32'h80) begin
            tests_failed++;
            $display("FAIL full_stall got prev=%0b busy=%h exp 1/%h", stall_prev, busy_mask, 32'h80);
        end
        tick();
        wb(5'd7);
        tests_run++;
        if (stall_prev !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_wb_cycle got %0b exp 1", stall_prev);
        end
        tick();
        exp_perf += 2;
        wb_valid = 1'b0;
        #1;
        tests_run++;
        if (stall_prev !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_fourth_fire got %0b exp 0", stall_prev);
        end
        tick();
        tests_run++;
        if (stall_prev !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_refilled got %0b exp 1", stall_prev);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            wb(5'd7);
            tick();
        end
        idle();
        tests_run++;
        if (busy_mask !== 32'h0 || hazard_stall_cycles !== 32'(exp_perf)) begin
            tests_failed++;
            $display("FAIL full_drain got busy=%h perf=%0d exp 0/%0d",
                     busy_mask, hazard_stall_cycles, exp_perf);
        end
    endtask

    task automatic test_same_cycle();
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        tick();
        wb(5'd9);
        tests_run++;
        if (stall_prev !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_fire got %0b exp 0", stall_prev);
        end
        tick();
        idle();
        tests_run++;
        if (busy_mask !== 32'h200) begin
            tests_failed++;
            $display("FAIL same_busy got %h exp %h", busy_mask, 32'h200);
        end
        wb(5'd9);
        tick();
        idle();
        tests_run++;
        if (busy_mask !== 32'h0 || underflow_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_count_one got busy=%h uf=%0b exp 0/0", busy_mask, underflow_err);
        end
    endtask

    task automatic test_x0();
        for (int i = 0; i < 5; i++) begin
            present(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
            tests_run++;
            if (stall_prev !== 1'b0 || busy_mask !== 32'h0) begin
                tests_failed++;
                $display("FAIL x0_issue%0d got prev=%0b busy=%h exp 0/0", i, stall_prev, busy_mask);
            end
            tick();
        end
        idle();
        wb(5'd0);
        tick();
        idle();
        tests_run++;
        if (underflow_err !== 1'b0 || busy_mask !== 32'h0) begin
            tests_failed++;
            $display("FAIL x0_wb got uf=%0b busy=%h exp 0/0", underflow_err, busy_mask);
        end
    endtask

    task automatic test_underflow();
        wb(5'd12);
        tick();
        idle();
        tests_run++;
        if (underflow_err !== 1'b1 || busy_mask !== 32'h0) begin
            tests_failed++;
            $display("FAIL uf_set got uf=%0b busy=%h exp 1/0", underflow_err, busy_mask);
        end
        flush = 1'b1;
        tick();
        idle();
        tests_run++;
        if (underflow_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL uf_after_flush got %0b exp 1", underflow_err);
        end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 3; r++) begin
            present(5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1);
            tick();
        end
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
        flush = 1'b1;
        #1;
        tests_run++;
        if (busy_mask !== 32'hE || stall_prev !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_pre got busy=%h prev=%0b exp %h/0", busy_mask, stall_prev, 32'hE);
        end
        tick();
        idle();
        tests_run++;
        if (busy_mask !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush_discard got %h exp 0", busy_mask);
        end
        for (int r = 1; r <= 3; r++) begin
            present(5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1);
            tick();
        end
        present(5'd2, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
        tests_run++;
        if (stall_prev !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_dep_stall got %0b exp 1", stall_prev);
        end
        tick();
        exp_perf += 1;
        flush = 1'b1;
        #1;
        tests_run++;
        if (stall_prev !== 1'b1 || stall_next !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_cycle_stalls got prev=%0b next=%0b exp 1/1", stall_prev, stall_next);
        end
        tick();
        flush = 1'b0;
        #1;
        tests_run++;
        if (busy_mask !== 32'h0 || stall_prev !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_release got busy=%h prev=%0b exp 0/0", busy_mask, stall_prev);
        end
        tick();
        idle();
        tests_run++;
        if (busy_mask !== 32'h10 || hazard_stall_cycles !== 32'(exp_perf) || underflow_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_after got busy=%h perf=%0d uf=%0b exp %h/%0d/1",
                     busy_mask, hazard_stall_cycles, underflow_err, 32'h10, exp_perf);
        end
        wb(5'd4);
        tick();
        idle();
    endtask

    task automatic test_next_stalled();
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
        next_stalled = 1'b1;
        #1;
        tests_run++;
        if (stall_prev !== 1'b1 || stall_next !== 1'b0) begin
            tests_failed++;
            $display("FAIL ns_stalls got prev=%0b next=%0b exp 1/0", stall_prev, stall_next);
        end
        tick();
        idle();
        tests_run++;
        if (busy_mask !== 32'h0 || hazard_stall_cycles !== 32'(exp_perf)) begin
            tests_failed++;
            $display("FAIL ns_no_issue got busy=%h perf=%0d exp 0/%0d",
                     busy_mask, hazard_stall_cycles, exp_perf);
        end
    endtask

    task automatic test_final_reset();
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (underflow_err !== 1'b0 || hazard_stall_cycles !== 32'd0 || busy_mask !== 32'h0) begin
            tests_failed++;
            $display("FAIL final_reset got uf=%0b perf=%0d busy=%h exp 0/0/0",
                     underflow_err, hazard_stall_cycles, busy_mask);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_perf     = 0;
        rst          = 1'b1;
        idle();
        test_reset();
        test_raw();
        test_full();
        test_same_cycle();
        test_x0();
        test_underflow();
        test_flush();
        test_next_stalled();
        test_final_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
